button_debouncer: RTL and testbench
===================================

# button_debouncer

Debounces one asynchronous mechanical input (push-button or switch) into clean single-clock events. It synchronises the raw signal, requires it to stay stable for a programmable number of cycles, and emits one-cycle press and release pulses plus a debounced level. It sits directly upstream of the pulse_cleaner stage: `btn_press` drives that stage's `pulse_in`. It also reports how many bounces it has rejected.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a change; legal range ≥ 2. The internal counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `clk`  in  1  single clock; all flops are on the rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  asynchronous raw input, active high (1 = pressed).
- `btn_level`  out  1  debounced level.
- `btn_press`  out  1  one-cycle pulse on an accepted 0→1 change; feeds pulse_cleaner `pulse_in`.
- `btn_release`  out  1  one-cycle pulse on an accepted 1→0 change.
- `busy`  out  1  high while a candidate change is being qualified.
- `bounce_cnt`  out  8  saturating count of rejected candidate changes.

## Operation
- **Synchroniser:** `btn_raw` passes through a `SYNC_STAGES`-deep flop chain; `sync` is the last stage. Only `sync` is used downstream of the chain.
- **State machine** (states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), with counter `cnt`:
  - RELEASED: if `sync` = 1, go to PRESS_WAIT and set `cnt` = 1.
  - PRESS_WAIT:
    - if `sync` = 0, go to RELEASED, clear `cnt`, and increment `bounce_cnt`;
    - else if `cnt` = `DEBOUNCE_CYCLES`-1, go to PRESSED, clear `cnt`, and assert `btn_press` for the next cycle;
    - else increment `cnt`.
  - PRESSED: if `sync` = 0, go to RELEASE_WAIT and set `cnt` = 1.
  - RELEASE_WAIT: mirror of PRESS_WAIT with polarity inverted:
    - if `sync` = 1, go back to PRESSED and increment `bounce_cnt`;
    - on reaching the count, go to RELEASED and assert `btn_release`.
- **Outputs:**
  - `btn_level` = 1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
  - `btn_press` and `btn_release` are registered and high for exactly one cycle per accepted edge. They are never high together.
  - `busy` = 1 in PRESS_WAIT and RELEASE_WAIT, and is registered with the state.
  - `bounce_cnt` saturates at 255 and holds there. It is cleared only by reset.
- **Behaviour under long activity:** a stable input produces exactly one event per change. Continuous bouncing produces no events, only `bounce_cnt` increments.

## Timing
- **Reset:** while `resetb` = 0, all outputs, the synchroniser flops, `cnt` and `bounce_cnt` are 0, and the state is RELEASED. Reset acts immediately and asynchronously. Reset asserted mid-qualification discards the partial count; no event is emitted.
- **Button held through reset deassertion:** the input qualifies normally after reset is released, and one `btn_press` is emitted.
- **Press latency:** `btn_raw` is stable high before rising edge E0.
  - `sync` = 1 after edge E(`SYNC_STAGES`-1).
  - The FSM enters PRESS_WAIT at edge E(`SYNC_STAGES`).
  - The state moves to PRESSED at edge E(`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1).
  - `btn_press` and `btn_level` become 1 after that same edge; with defaults, after E17.
- **Release latency:** same count as press latency.
- **Acceptance boundary:**
  - A `sync` run of exactly `DEBOUNCE_CYCLES` samples is accepted.
  - A run of `DEBOUNCE_CYCLES`-1 samples is rejected, with one `bounce_cnt` increment.
- **Minimum event spacing:** consecutive press and release events are at least `DEBOUNCE_CYCLES` cycles apart.

## Test plan
1. **Clean press:** reset, then `btn_raw`=1 held 40 cycles → a single `btn_press` pulse after edge E17. `btn_level`=1 from the same cycle. `busy` is high for 15 cycles. `bounce_cnt`=0.
2. **Boundary:** a `btn_raw` high pulse of 15 cycles → no `btn_press`, `bounce_cnt`=1. A high pulse of 16 cycles → exactly one `btn_press`.
3. **Bounce train then stable:** three 4-cycle highs separated by 4-cycle lows, then held high → `bounce_cnt`=3 and exactly one `btn_press`, 18 edges after the final rise.
4. **Release:** from PRESSED, `btn_raw`=0 held → one `btn_release` pulse after 18 edges. `btn_level` goes to 0 the same cycle. `btn_press` never fires.
5. **Saturation:** 300 rejected 3-cycle glitches → `bounce_cnt`=255 and no events.
6. **Reset mid-qualification:** `resetb` asserted 8 cycles into PRESS_WAIT → all outputs 0 immediately. After release with `btn_raw` still high → one `btn_press`, 18 edges after the first post-reset edge.

Source files
------------

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronises and debounces one raw button input into a clean
//            level, one-cycle press/release pulses and a rejected-bounce count.
// Revision : 1.0 - initial release
// ============================================================================

module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       busy,
    output logic [7:0] bounce_cnt
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   w_press_nxt;
    logic                   w_release_nxt;
    logic                   w_bounce_inc;
    logic                   w_level_nxt;
    logic                   w_busy_nxt;

    logic                   r_press;
    logic                   r_release;
    logic                   r_level;
    logic                   r_busy;
    logic [7:0]             r_bounce;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Each *_WAIT state counts consecutive samples of the candidate level;
    // the sample that entered the state is already count 1.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_bounce_inc  = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_sync) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt  = ST_RELEASED;
                    w_cnt_nxt    = c_cnt_zero;
                    w_bounce_inc = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = c_cnt_zero;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_sync) begin
                    w_state_nxt  = ST_PRESSED;
                    w_cnt_nxt    = c_cnt_zero;
                    w_bounce_inc = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt   = ST_RELEASED;
                    w_cnt_nxt     = c_cnt_zero;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
        w_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
        w_busy_nxt  = (w_state_nxt == ST_PRESS_WAIT) || (w_state_nxt == ST_RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_level   <= 1'b0;
            r_busy    <= 1'b0;
            r_bounce  <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_level   <= w_level_nxt;
            r_busy    <= w_busy_nxt;
            if (w_bounce_inc && (r_bounce != 8'hFF)) begin
                r_bounce <= r_bounce + 8'd1;
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign busy        = r_busy;
    assign bounce_cnt  = r_bounce;

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Self-checking bench for button_debouncer using a run-length model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_button_debouncer;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 16;

    logic       clk = 1'b0;
    logic       resetb;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic       busy;
    logic [7:0] bounce_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .busy       (busy),
        .bounce_cnt (bounce_cnt)
    );

    always #5 clk = ~clk;

    // Reference: a delay line for the synchroniser, then the accepted level
    // flips once DEBOUNCE_CYCLES consecutive samples disagree with it.
    logic m_q[$];
    logic m_level = 1'b0;
    logic m_press = 1'b0;
    logic m_rel   = 1'b0;
    int   m_run    = 0;
    int   m_bounce = 0;

    always @(posedge clk or negedge resetb) begin : p_model
        logic s;
        if (!resetb) begin
            m_q.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_q.push_back(1'b0);
            m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
            m_run = 0; m_bounce = 0;
        end else begin
            s = m_q.pop_front();
            m_q.push_back(btn_raw);
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (s != m_level) begin
                m_run = m_run + 1;
                if (m_run == DEBOUNCE_CYCLES) begin
                    m_level = s;
                    m_run   = 0;
                    if (s) m_press = 1'b1;
                    else   m_rel   = 1'b1;
                end
            end else begin
                if (m_run > 0 && m_bounce < 255) m_bounce = m_bounce + 1;
                m_run = 0;
            end
        end
    end

    int          t_idx, t_press, t_rel, t_both, t_busy, t_mis;
    int          t_press_idx, t_rel_idx, t_up_idx, t_dn_idx;
    int          t_last_evt, t_min_gap;
    logic        t_prev_lvl;
    logic [11:0] t_mis_act, t_mis_exp;

    task automatic clear_tally();
        t_idx = 0; t_press = 0; t_rel = 0; t_both = 0; t_busy = 0; t_mis = 0;
        t_press_idx = -1; t_rel_idx = -1; t_up_idx = -1; t_dn_idx = -1;
        t_last_evt = -1000000; t_min_gap = 1000000;
        t_prev_lvl = btn_level;
        t_mis_act = '0; t_mis_exp = '0;
    endtask

    // Drives btn_raw for n cycles (starting at a negedge) and tallies what
    // the DUT did after each rising edge, including divergence from the model.
    task automatic run_cycles(input logic v, input int n);
        logic [11:0] act, exp;
        btn_raw = v;
        repeat (n) begin
            @(negedge clk);
            act = {btn_level, btn_press, btn_release, busy, bounce_cnt};
            exp = {m_level, m_press, m_rel, (m_run != 0), m_bounce[7:0]};
            if (act !== exp) begin
                if (t_mis == 0) begin t_mis_act = act; t_mis_exp = exp; end
                t_mis++;
            end
            if (btn_press)   begin t_press++; t_press_idx = t_idx; end
            if (btn_release) begin t_rel++;   t_rel_idx   = t_idx; end
            if (btn_press && btn_release) t_both++;
            if (busy) t_busy++;
            if (btn_press || btn_release) begin
                if (t_idx - t_last_evt < t_min_gap) t_min_gap = t_idx - t_last_evt;
                t_last_evt = t_idx;
            end
            if (btn_level && !t_prev_lvl && t_up_idx < 0) t_up_idx = t_idx;
            if (!btn_level && t_prev_lvl && t_dn_idx < 0) t_dn_idx = t_idx;
            t_prev_lvl = btn_level;
            t_idx++;
        end
    endtask

    task automatic do_reset(input logic raw);
        btn_raw = raw;
        resetb  = 1'b0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        btn_raw = 1'b1;
        resetb  = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({btn_level, btn_press, btn_release, busy, bounce_cnt} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {btn_level, btn_press, btn_release, busy, bounce_cnt});
        end
        resetb = 1'b1;
        clear_tally();
        run_cycles(1'b1, 40);
        n_tests++;
        if (t_press !== 1 || t_press_idx !== 17) begin
            n_fail++;
            $display("FAIL held_through_reset: got %0d presses at %0d expected 1 at 17", t_press, t_press_idx);
        end
        n_tests++;
        if (t_mis !== 0) begin
            n_fail++;
            $display("FAIL held_model: %0d diffs first got %h expected %h", t_mis, t_mis_act, t_mis_exp);
        end
    endtask

    task automatic test_clean_press();
        do_reset(1'b0);
        clear_tally();
        run_cycles(1'b1, 40);
        n_tests++;
        if (t_press !== 1 || t_press_idx !== 17) begin
            n_fail++;
            $display("FAIL press_timing: got %0d presses at %0d expected 1 at 17", t_press, t_press_idx);
        end
        n_tests++;
        if (t_up_idx !== 17) begin
            n_fail++;
            $display("FAIL press_level: got rise at %0d expected 17", t_up_idx);
        end
        n_tests++;
        if (t_busy !== 15) begin
            n_fail++;
            $display("FAIL press_busy: got %0d cycles expected 15", t_busy);
        end
        n_tests++;
        if (bounce_cnt !== 8'd0 || t_mis !== 0) begin
            n_fail++;
            $display("FAIL press_bounce_model: got bounce %0d diffs %0d expected 0 0", bounce_cnt, t_mis);
        end
    endtask

    task automatic test_boundary();
        do_reset(1'b0);
        clear_tally();
        run_cycles(1'b1, DEBOUNCE_CYCLES - 1);
        run_cycles(1'b0, 30);
        n_tests++;
        if (t_press !== 0 || bounce_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL boundary_short: got presses %0d bounce %0d expected 0 1", t_press, bounce_cnt);
        end
        clear_tally();
        run_cycles(1'b1, DEBOUNCE_CYCLES);
        run_cycles(1'b0, 40);
        n_tests++;
        if (t_press !== 1 || t_rel !== 1 || bounce_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL boundary_exact: got press %0d rel %0d bounce %0d expected 1 1 1", t_press, t_rel, bounce_cnt);
        end
        n_tests++;
        if (t_min_gap < DEBOUNCE_CYCLES || t_mis !== 0) begin
            n_fail++;
            $display("FAIL boundary_gap_model: got gap %0d diffs %0d expected >=%0d 0", t_min_gap, t_mis, DEBOUNCE_CYCLES);
        end
    endtask

    task automatic test_bounce_train();
        do_reset(1'b0);
        repeat (3) begin
            run_cycles(1'b1, 4);
            run_cycles(1'b0, 4);
        end
        clear_tally();
        run_cycles(1'b1, 40);
        n_tests++;
        if (bounce_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL train_bounce: got %0d expected 3", bounce_cnt);
        end
        n_tests++;
        if (t_press !== 1 || t_press_idx !== 17 || t_mis !== 0) begin
            n_fail++;
            $display("FAIL train_press: got %0d at %0d diffs %0d expected 1 at 17 0", t_press, t_press_idx, t_mis);
        end
    endtask

    task automatic test_release();
        clear_tally();
        run_cycles(1'b0, 40);
        n_tests++;
        if (t_rel !== 1 || t_rel_idx !== 17) begin
            n_fail++;
            $display("FAIL release_timing: got %0d at %0d expected 1 at 17", t_rel, t_rel_idx);
        end
        n_tests++;
        if (t_dn_idx !== 17 || t_press !== 0) begin
            n_fail++;
            $display("FAIL release_level: got fall %0d presses %0d expected 17 0", t_dn_idx, t_press);
        end
        n_tests++;
        if (t_mis !== 0) begin
            n_fail++;
            $display("FAIL release_model: %0d diffs first got %h expected %h", t_mis, t_mis_act, t_mis_exp);
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        clear_tally();
        repeat (100) begin
            run_cycles(1'b1, 3);
            run_cycles(1'b0, 3);
        end
        n_tests++;
        if (bounce_cnt !== 8'd100) begin
            n_fail++;
            $display("FAIL sat_partial: got %0d expected 100", bounce_cnt);
        end
        repeat (200) begin
            run_cycles(1'b1, 3);
            run_cycles(1'b0, 3);
        end
        n_tests++;
        if (bounce_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final: got %0d expected 255", bounce_cnt);
        end
        n_tests++;
        if (t_press + t_rel !== 0 || t_mis !== 0) begin
            n_fail++;
            $display("FAIL sat_events_model: got events %0d diffs %0d expected 0 0", t_press + t_rel, t_mis);
        end
    endtask

    task automatic test_reset_mid_qual();
        do_reset(1'b0);
        clear_tally();
        run_cycles(1'b1, 10);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midq_busy: got %b expected 1", busy);
        end
        #2 resetb = 1'b0;
        #1;
        n_tests++;
        if ({btn_level, btn_press, btn_release, busy, bounce_cnt} !== 12'd0) begin
            n_fail++;
            $display("FAIL midq_async_clear: got %h expected 000",
                     {btn_level, btn_press, btn_release, busy, bounce_cnt});
        end
        @(negedge clk);
        resetb = 1'b1;
        clear_tally();
        run_cycles(1'b1, 40);
        n_tests++;
        if (t_press !== 1 || t_press_idx !== 17 || t_mis !== 0) begin
            n_fail++;
            $display("FAIL midq_press: got %0d at %0d diffs %0d expected 1 at 17 0", t_press, t_press_idx, t_mis);
        end
    endtask

    task automatic test_random();
        logic v;
        do_reset(1'b0);
        clear_tally();
        v = 1'b1;
        for (int seg = 0; seg < 80; seg++) begin
            run_cycles(v, int'($urandom_range(1, 28)));
            v = ~v;
        end
        run_cycles(1'b0, 40);
        n_tests++;
        if (t_mis !== 0) begin
            n_fail++;
            $display("FAIL random_model: %0d diffs first got %h expected %h", t_mis, t_mis_act, t_mis_exp);
        end
        n_tests++;
        if (t_both !== 0 || t_press !== t_rel) begin
            n_fail++;
            $display("FAIL random_events: got both %0d press %0d rel %0d expected 0 and equal", t_both, t_press, t_rel);
        end
        n_tests++;
        if ((t_press + t_rel) >= 2 && t_min_gap < DEBOUNCE_CYCLES) begin
            n_fail++;
            $display("FAIL random_gap: got %0d expected >= %0d", t_min_gap, DEBOUNCE_CYCLES);
        end
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        btn_raw = 1'b0;
        resetb  = 1'b0;
        test_reset();
        test_clean_press();
        test_boundary();
        test_bounce_train();
        test_release();
        test_saturation();
        test_reset_mid_qual();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
